// File: rtl/fb_read_pkg.sv
// Shared types and constants for the framebuffer read sequencer.
package fb_read_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } fb_state_e;

  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned BRAM_RD_LAT = 1;

endpackage

// File: rtl/fb_pix_skid_fifo.sv
// Two-entry first-word-fall-through pixel FIFO; a write into an empty FIFO is
// presented on the read side in the same cycle and is only stored if not taken.
module fb_pix_skid_fifo
  import fb_read_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;
  logic [1:0]        w_occ_nxt;
  logic              w_bypass;
  logic              w_pop;
  logic              w_store;
  logic              w_deq;

  always_comb begin
    w_bypass   = (r_occ == 2'd0) && wr_en_i;
    rd_valid_o = (r_occ != 2'd0) || wr_en_i;
    rd_data_o  = w_bypass ? wr_data_i : r_mem[r_rptr];
    w_pop      = rd_valid_o && rd_ready_i;
    w_store    = wr_en_i && !(w_bypass && w_pop);
    w_deq      = w_pop && !w_bypass;
    w_occ_nxt  = r_occ + {1'b0, w_store} - {1'b0, w_deq};
  end

  assign occ_o = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wptr] <= wr_data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq) begin
        r_rptr <= ~r_rptr;
      end
      r_occ <= w_occ_nxt;
    end
  end

endmodule

// File: rtl/fb_read_sequencer.sv
// Framebuffer BRAM port-B read sequencer streaming pixels over valid/ready.
// Optional FB_READ_LOOP_EN adds loop_i for continuous multi-pass runs.
module fb_read_sequencer
  import fb_read_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  pix_count_i,
  input  logic              abort_i,
`ifdef FB_READ_LOOP_EN
  input  logic              loop_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              bram_en_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic              pix_valid_o,
  output logic [DATA_W-1:0] pix_data_o,
  input  logic              pix_ready_i
);

  fb_state_e         r_state;
  fb_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_remain;
  logic [CNT_W-1:0]  r_out_left;
  logic              r_inflight;
  logic              r_done_zero;

  logic [1:0]        w_occ;
  logic [2:0]        w_outstanding;
  logic              w_active;
  logic              w_abort;
  logic              w_start;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_xfer;
  logic              w_pass_end;
  logic              w_loop;

`ifdef FB_READ_LOOP_EN
  assign w_loop = loop_i;
`else
  assign w_loop = 1'b0;
`endif

  fb_pix_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (w_abort),
    .wr_en_i    (r_inflight),
    .wr_data_i  (bram_dout_i),
    .rd_ready_i (pix_ready_i),
    .rd_valid_o (pix_valid_o),
    .rd_data_o  (pix_data_o),
    .occ_o      (w_occ)
  );

  // Credit: stored pixels plus the read in flight never exceed the FIFO depth.
  always_comb begin
    w_active      = (r_state != StIdle);
    w_abort       = abort_i && w_active;
    w_start       = (r_state == StIdle) && start_i && (pix_count_i != '0);
    w_outstanding = {1'b0, w_occ} + {2'b00, r_inflight};
    w_issue       = (r_state == StRun) && !w_abort && (w_outstanding < 3'(FIFO_DEPTH));
    w_last_issue  = w_issue && (r_remain == CNT_W'(1));
    w_xfer        = pix_valid_o && pix_ready_i;
    // Every pass has the same length, so a wrapping counter marks pass ends.
    w_pass_end    = w_xfer && (r_out_left == CNT_W'(1));
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_nxt = StRun;
      end
      StRun: begin
        if (w_abort) w_state_nxt = StIdle;
        else if (w_last_issue && !w_loop) w_state_nxt = StDrain;
      end
      StDrain: begin
        if (w_abort) w_state_nxt = StIdle;
        else if (w_xfer && (w_outstanding == 3'd1)) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_base      <= '0;
      r_count     <= '0;
      r_remain    <= '0;
      r_out_left  <= '0;
      r_inflight  <= 1'b0;
      r_done_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_inflight  <= w_issue;
      r_done_zero <= (r_state == StIdle) && start_i && (pix_count_i == '0);
      if (w_start) begin
        r_base     <= base_addr_i;
        r_count    <= pix_count_i;
        r_addr     <= base_addr_i;
        r_remain   <= pix_count_i;
        r_out_left <= pix_count_i;
      end else begin
        if (w_issue) begin
          if (w_last_issue && w_loop) begin
            r_addr   <= r_base;
            r_remain <= r_count;
          end else begin
            r_addr   <= (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
            r_remain <= r_remain - CNT_W'(1);
          end
        end
        if (w_xfer && !w_abort) begin
          r_out_left <= w_pass_end ? r_count : r_out_left - CNT_W'(1);
        end
      end
    end
  end

  assign busy_o      = w_active;
  assign done_o      = (w_pass_end && !w_abort) || r_done_zero;
  assign bram_en_o   = w_issue;
  assign bram_addr_o = r_addr;

endmodule
